// File: rtl/reg_file_wb_if.sv
// reg_file_wb_if
// Groups the write-back, decode-read and issue signals of the register file.
//   master : the pipeline side (MEM/WB drives write-back, decode drives reads
//            and issue, and it consumes read data and the stall)
//   slave  : the register file itself
// Signals:
//   writeEnableIn/writeBackAddrIn/dataIn : write-back triple from MEM/WB
//   readEnable1/readAddr1, readEnable2/readAddr2 : decode source reads
//   issueValid/issueAddr : decode issues an instruction writing issueAddr
//   readData1/readData2 : combinational source data
//   pendingStall : combinational hold request to decode
// Issue handshake: an issue is taken only in a cycle where issueValid is high
// and pendingStall is low; an issue presented while pendingStall is high is
// dropped and has no effect.
interface reg_file_wb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              writeEnableIn;
    logic [ADDR_W-1:0] writeBackAddrIn;
    logic [DATA_W-1:0] dataIn;
    logic              readEnable1;
    logic [ADDR_W-1:0] readAddr1;
    logic              readEnable2;
    logic [ADDR_W-1:0] readAddr2;
    logic              issueValid;
    logic [ADDR_W-1:0] issueAddr;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              pendingStall;

    modport master (
        output writeEnableIn, writeBackAddrIn, dataIn,
        output readEnable1, readAddr1, readEnable2, readAddr2,
        output issueValid, issueAddr,
        input  readData1, readData2, pendingStall
    );

    modport slave (
        input  writeEnableIn, writeBackAddrIn, dataIn,
        input  readEnable1, readAddr1, readEnable2, readAddr2,
        input  issueValid, issueAddr,
        output readData1, readData2, pendingStall
    );
endinterface

// File: rtl/reg_file_wb.sv
// reg_file_wb
// Architectural register file with a write-back scoreboard. Commits the
// MEM/WB write-back triple into a NUM_REGS x DATA_W array (x0 hardwired to
// zero), serves two decode read ports with same-cycle write-through bypass,
// and tracks in-flight destinations so decode stalls on RAW/WAW hazards.
// Ports:
//   clk     : rising-edge clock
//   resetIn : synchronous active-high reset; clears array and pending bits,
//             forces all outputs to zero while high
//   wb      : reg_file_wb_if slave (write-back, reads, issue, stall)
module reg_file_wb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic         clk,
    input  logic         resetIn,
    reg_file_wb_if.slave wb
);
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    logic bypass1, bypass2, bypass_iss;
    logic src_haz1, src_haz2, waw_haz;
    logic stall;
    logic issue_accept;
    logic wb_commit;

    // A write-back addressed at a register resolves that register's hazard
    // in the same cycle, since its data is available through the bypass.
    assign bypass1    = wb.writeEnableIn && (wb.writeBackAddrIn == wb.readAddr1);
    assign bypass2    = wb.writeEnableIn && (wb.writeBackAddrIn == wb.readAddr2);
    assign bypass_iss = wb.writeEnableIn && (wb.writeBackAddrIn == wb.issueAddr);

    assign src_haz1 = wb.readEnable1 && (wb.readAddr1 != '0)
                      && pending_q[wb.readAddr1] && !bypass1;
    assign src_haz2 = wb.readEnable2 && (wb.readAddr2 != '0)
                      && pending_q[wb.readAddr2] && !bypass2;
    assign waw_haz  = wb.issueValid && (wb.issueAddr != '0)
                      && pending_q[wb.issueAddr] && !bypass_iss;

    assign stall           = !resetIn && (src_haz1 || src_haz2 || waw_haz);
    assign wb.pendingStall = stall;

    // Issues presented while stalled are ignored rather than queued.
    assign issue_accept = wb.issueValid && (wb.issueAddr != '0) && !stall;
    assign wb_commit    = wb.writeEnableIn && (wb.writeBackAddrIn != '0);

    always_comb begin
        wb.readData1 = '0;
        if (!resetIn && wb.readEnable1 && (wb.readAddr1 != '0)) begin
            wb.readData1 = bypass1 ? wb.dataIn : regs_q[wb.readAddr1];
        end
    end

    always_comb begin
        wb.readData2 = '0;
        if (!resetIn && wb.readEnable2 && (wb.readAddr2 != '0)) begin
            wb.readData2 = bypass2 ? wb.dataIn : regs_q[wb.readAddr2];
        end
    end

    // Clear first, then set: a new producer issued to the register being
    // written back is still outstanding, so the set must win.
    always_comb begin
        pending_d = pending_q;
        if (wb.writeEnableIn) begin
            pending_d[wb.writeBackAddrIn] = 1'b0;
        end
        if (issue_accept) begin
            pending_d[wb.issueAddr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (resetIn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
        end else begin
            if (wb_commit) begin
                regs_q[wb.writeBackAddrIn] <= wb.dataIn;
            end
            pending_q <= pending_d;
        end
    end
endmodule

// File: doc/reg_file_wb.md
# reg_file_wb

Architectural register file with write-back scoreboard: the consumer end of the MEM→WB write-back interface. It accepts the write-back triple (enable, address, data) from the MEM/WB pipeline register and commits it to a 32-entry register array. It serves two read ports to the decode stage, with same-cycle write-through bypass. It also tracks in-flight destination registers, so decode can stall on RAW/WAW hazards until the producing write-back lands.

## Interface
Parameters:
- DATA_W, 32, register data width (matches `DataSize`)
- ADDR_W, 5, register address width (matches `RegAddrSize`)
- NUM_REGS, 32, number of registers (2**ADDR_W)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- resetIn  in  1  reset, synchronous, active-high
- writeEnableIn  in  1  write-back valid from MEM/WB
- writeBackAddrIn  in  ADDR_W  write-back destination register
- dataIn  in  DATA_W  write-back data from MEM/WB
- readEnable1  in  1  source-1 read valid from decode
- readAddr1  in  ADDR_W  source-1 register
- readEnable2  in  1  source-2 read valid from decode
- readAddr2  in  ADDR_W  source-2 register
- issueValid  in  1  decode issues an instruction that writes issueAddr
- issueAddr  in  ADDR_W  destination of issuing instruction
- readData1  out  DATA_W  source-1 data (combinational)
- readData2  out  DATA_W  source-2 data (combinational)
- pendingStall  out  1  decode must hold (combinational)

## Operation
- Array: NUM_REGS x DATA_W registers. Register 0 is hardwired to zero; writes to it are discarded.
- Write: on a rising edge, if writeEnableIn && writeBackAddrIn != 0 && !resetIn, then reg[writeBackAddrIn] <= dataIn.
- Read port n:
  - readDatan = 0 if resetIn, !readEnablen, or readAddrn == 0.
  - Otherwise, dataIn if writeEnableIn && writeBackAddrIn == readAddrn (bypass).
  - Otherwise, reg[readAddrn].
- Scoreboard: NUM_REGS-bit pending vector; bit 0 is always 0.
  - Set: issueValid && issueAddr != 0 sets pending[issueAddr] at the edge.
  - Clear: writeEnableIn clears pending[writeBackAddrIn] at the edge.
  - Set and clear on the same address in the same cycle: set wins, because the new producer is outstanding.
- pendingStall = srcHaz1 | srcHaz2 | wawHaz, where:
  - srcHazn = readEnablen && readAddrn != 0 && pending[readAddrn] && !(writeEnableIn && writeBackAddrIn == readAddrn).
  - wawHaz = issueValid && issueAddr != 0 && pending[issueAddr] && !(writeEnableIn && writeBackAddrIn == issueAddr).
- Protocol rule: decode drives issueValid only when pendingStall is low. If issueValid is high while pendingStall is high, the block ignores the issue and leaves the pending vector unchanged.
- Write-back with no matching pending bit (for example, after a flush) still writes the array. The clear is a no-op.

## Timing
- Reset (resetIn high at an edge): all registers become 0 and all pending bits become 0. While resetIn is high, readData1, readData2 and pendingStall are forced to 0. Write-back during reset is dropped.
- Write latency: data appears on a read port in the same cycle through the bypass. It is visible from the array from the next cycle onward.
- Scoreboard latency: a pending bit set at edge N affects pendingStall from cycle N+1. A write-back in cycle M removes the stall in cycle M combinationally.
- Reset mid-operation: pending state is lost. Write-backs still in flight after reset release write the array but do not stall anyone.
- Outputs are purely combinational from the registered state plus the current inputs. There are no registered output stages.

## Test plan
- Reset, then read x1..x31 with enables high → all 0. pendingStall = 0.
- Write 0xDEADBEEF to x5, then read x5 with readAddr1 = 5 in the same cycle → readData1 = 0xDEADBEEF (bypass). The next cycle, with writeEnableIn low → still 0xDEADBEEF.
- Write 0x1234 to x0, then read x0 on both ports → 0. Issue to x0 → pendingStall stays 0.
- Issue to x7. Next cycle, read x7 → pendingStall = 1. Two cycles later, write-back to x7 with 0x55 → pendingStall = 0 and readData1 = 0x55 in that cycle.
- x9 pending. In the same cycle, write-back to x9 and issue to x9 (stall low due to bypass) → next cycle pending[9] = 1. A read of x9 stalls.
- Set pending bits on x3 and x4, assert resetIn for 1 cycle, then read x3 → pendingStall = 0, readData1 = 0.
